// File: rtl/spi_slave_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_cmd_decoder
// Description : Turns SPI slave byte frames into register-bus accesses.
//               Command byte: bit7 = read, low bits = start address.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_cmd_decoder #(
    parameter int ADDR_W = 7
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              ss,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    input  logic              rx_error,
    input  logic              tx_reg_empty,
    output logic              rx_reg_re,
    output logic [7:0]        tx_data,
    output logic              tx_reg_we,
    output logic              clear_error,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              status_clr,
    output logic              rx_ovr_flag,
    output logic              tx_ovr_flag
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR_DATA  = 3'd2,
        RD_FETCH = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_ss_meta;
    logic              r_ss_s;
    logic [1:0]        r_ss_primed;
    logic              r_armed;

    logic              r_rx_reg_re;
    logic              r_tx_reg_we;
    logic              r_clear_error;
    logic              r_reg_we;
    logic              r_reg_re;
    logic              r_rx_ovr_flag;
    logic              r_tx_ovr_flag;
    logic [7:0]        r_tx_data;
    logic [7:0]        r_reg_wdata;
    logic [ADDR_W-1:0] r_reg_addr;

    logic              w_accept;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_wdata_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic              w_reg_we_nxt;
    logic              w_reg_re_nxt;
    logic              w_tx_we_nxt;
    logic              w_tx_ovr_set;

    // r_armed only rises once ss_s has been genuinely sampled high, so a frame
    // that was open across reset is never decoded.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_ss_meta   <= 1'b1;
            r_ss_s      <= 1'b1;
            r_ss_primed <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_ss_meta   <= ss;
            r_ss_s      <= r_ss_meta;
            r_ss_primed <= {r_ss_primed[0], 1'b1};
            if (r_ss_primed[1] && r_ss_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // The read strobe already in flight blocks re-acceptance of the same byte.
    assign w_accept = rx_data_ready && !r_rx_reg_re;

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_reg_addr;
        w_wdata_nxt   = r_reg_wdata;
        w_tx_data_nxt = r_tx_data;
        w_reg_we_nxt  = 1'b0;
        w_reg_re_nxt  = 1'b0;
        w_tx_we_nxt   = 1'b0;
        w_tx_ovr_set  = 1'b0;

        if (r_reg_we) begin
            w_addr_nxt = r_reg_addr + ADDR_W'(1);
        end

        case (r_state)
            IDLE: begin
                if (!r_ss_s && r_armed) begin
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                if (r_ss_s) begin
                    w_state_nxt = IDLE;
                end else if (w_accept) begin
                    w_addr_nxt = rx_data[ADDR_W-1:0];
                    if (rx_data[7]) begin
                        w_reg_re_nxt = 1'b1;
                        w_state_nxt  = RD_FETCH;
                    end else begin
                        w_state_nxt  = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (r_ss_s) begin
                    w_state_nxt = IDLE;
                end else if (w_accept) begin
                    w_wdata_nxt  = rx_data;
                    w_reg_we_nxt = 1'b1;
                end
            end
            RD_FETCH: begin
                // Read data is valid the cycle after reg_re; capture regardless of ss_s.
                if (!r_reg_re) begin
                    w_tx_data_nxt = reg_rdata;
                    w_tx_we_nxt   = 1'b1;
                    w_tx_ovr_set  = !tx_reg_empty;
                    w_state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (r_ss_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rx_reg_re   <= 1'b0;
            r_tx_reg_we   <= 1'b0;
            r_clear_error <= 1'b0;
            r_reg_we      <= 1'b0;
            r_reg_re      <= 1'b0;
            r_rx_ovr_flag <= 1'b0;
            r_tx_ovr_flag <= 1'b0;
            r_tx_data     <= 8'h00;
            r_reg_wdata   <= 8'h00;
            r_reg_addr    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rx_reg_re   <= w_accept;
            r_tx_reg_we   <= w_tx_we_nxt;
            r_clear_error <= rx_error && !r_clear_error;
            r_reg_we      <= w_reg_we_nxt;
            r_reg_re      <= w_reg_re_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_reg_wdata   <= w_wdata_nxt;
            r_reg_addr    <= w_addr_nxt;
            // A set event beats a simultaneous status_clr.
            if (rx_error) begin
                r_rx_ovr_flag <= 1'b1;
            end else if (status_clr) begin
                r_rx_ovr_flag <= 1'b0;
            end
            if (w_tx_ovr_set) begin
                r_tx_ovr_flag <= 1'b1;
            end else if (status_clr) begin
                r_tx_ovr_flag <= 1'b0;
            end
        end
    end

    assign rx_reg_re   = r_rx_reg_re;
    assign tx_data     = r_tx_data;
    assign tx_reg_we   = r_tx_reg_we;
    assign clear_error = r_clear_error;
    assign reg_addr    = r_reg_addr;
    assign reg_wdata   = r_reg_wdata;
    assign reg_we      = r_reg_we;
    assign reg_re      = r_reg_re;
    assign rx_ovr_flag = r_rx_ovr_flag;
    assign tx_ovr_flag = r_tx_ovr_flag;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_cmd_decoder
// Description : Frame vectors plus corner sequences against a strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_cmd_decoder;

    localparam int         ADDR_W = 7;
    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_TX  = 2'd2;

    logic              sysclk = 1'b0;
    logic              reset;
    logic              ss;
    logic [7:0]        rx_data;
    logic              rx_data_ready;
    logic              rx_error;
    logic              tx_reg_empty;
    logic              rx_reg_re;
    logic [7:0]        tx_data;
    logic              tx_reg_we;
    logic              clear_error;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              status_clr;
    logic              rx_ovr_flag;
    logic              tx_ovr_flag;

    spi_slave_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .ss           (ss),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_error     (rx_error),
        .tx_reg_empty (tx_reg_empty),
        .rx_reg_re    (rx_reg_re),
        .tx_data      (tx_data),
        .tx_reg_we    (tx_reg_we),
        .clear_error  (clear_error),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .status_clr   (status_clr),
        .rx_ovr_flag  (rx_ovr_flag),
        .tx_ovr_flag  (tx_ovr_flag)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    typedef struct packed {
        logic [2:0]      nb;
        logic [3:0][7:0] b;
        logic [7:0]      rdata;
        logic            tx_empty;
        logic            req_tx_ovr;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs [5];

    int         checks     = 0;
    int         errors     = 0;
    int         rx_ack_cnt = 0;
    int         clr_cnt    = 0;
    logic [7:0] rd_value   = 8'h00;
    logic       rd_pend    = 1'b0;

    // Register bank model: data appears the cycle after reg_re, garbage otherwise.
    always @(negedge sysclk) rd_pend = reg_re;
    always @(posedge sysclk) begin
        #1;
        reg_rdata = rd_pend ? rd_value : 8'hEE;
    end

    always @(negedge sysclk) begin
        int         ns;
        ev_t        e;
        logic [1:0] k;
        logic [7:0] a;
        logic [7:0] d;
        if (rx_reg_re === 1'b1) rx_ack_cnt++;
        if (clear_error === 1'b1) clr_cnt++;
        ns = 0;
        if (reg_we === 1'b1) ns++;
        if (reg_re === 1'b1) ns++;
        if (tx_reg_we === 1'b1) ns++;
        if (ns != 0) begin
            checks++;
            if (ns != 1) begin
                errors++;
                $display("FAIL strobe_overlap: reg_we=%b reg_re=%b tx_reg_we=%b, required at most one",
                         reg_we, reg_re, tx_reg_we);
            end
            if (reg_we === 1'b1) begin
                k = EV_WR; a = {1'b0, reg_addr}; d = reg_wdata;
            end else if (reg_re === 1'b1) begin
                k = EV_RD; a = {1'b0, reg_addr}; d = 8'h00;
            end else begin
                k = EV_TX; a = 8'h00; d = tx_data;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got kind=%0d addr=0x%02h data=0x%02h, required none", k, a, d);
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== k || e.addr !== a || e.data !== d) begin
                    errors++;
                    $display("FAIL strobe_event: got kind=%0d addr=0x%02h data=0x%02h, required kind=%0d addr=0x%02h data=0x%02h",
                             k, a, d, e.kind, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(posedge sysclk); #1;
        rx_data       = b;
        rx_data_ready = 1'b1;
        n = 0;
        @(negedge sysclk);
        while (rx_reg_re !== 1'b1 && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        if (rx_reg_re !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ack_timeout: byte 0x%02h got no rx_reg_re, required one within 20 cycles", b);
        end
        @(posedge sysclk); #1;
        rx_data_ready = 1'b0;
        repeat (2) @(posedge sysclk);
    endtask

    task automatic frame_begin();
        @(posedge sysclk); #1;
        ss = 1'b0;
        repeat (4) @(posedge sysclk);
    endtask

    task automatic frame_end();
        repeat (6) @(posedge sysclk); #1;
        ss = 1'b1;
        repeat (6) @(posedge sysclk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge sysclk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_status_clr();
        @(posedge sysclk); #1;
        status_clr = 1'b1;
        @(posedge sysclk); #1;
        status_clr = 1'b0;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_strobes_flags"},
            {25'd0, rx_reg_re, tx_reg_we, clear_error, reg_we, reg_re, rx_ovr_flag, tx_ovr_flag}, 0);
        chk({pfx, "_reg_addr"}, 32'(reg_addr), 0);
        chk({pfx, "_reg_wdata"}, 32'(reg_wdata), 0);
        chk({pfx, "_tx_data"}, 32'(tx_data), 0);
    endtask

    task automatic run_vec(input int idx);
        vec_t       v;
        logic [7:0] a;
        int         ack0;
        v            = vecs[idx];
        rd_value     = v.rdata;
        tx_reg_empty = v.tx_empty;
        a            = {1'b0, v.b[0][6:0]};
        if (v.b[0][7]) begin
            exp_q.push_back({EV_RD, a, 8'h00});
            exp_q.push_back({EV_TX, 8'h00, v.rdata});
        end else begin
            for (int i = 1; i < int'(v.nb); i++) begin
                exp_q.push_back({EV_WR, a, v.b[i[1:0]]});
                a = (a + 8'd1) & 8'h7F;
            end
        end
        ack0 = rx_ack_cnt;
        frame_begin();
        for (int i = 0; i < int'(v.nb); i++) send_byte(v.b[i[1:0]]);
        frame_end();
        wait_drain($sformatf("vec%0d_events", idx));
        chk($sformatf("vec%0d_rx_acks", idx), rx_ack_cnt - ack0, int'(v.nb));
        chk($sformatf("vec%0d_tx_ovr_flag", idx), 32'(tx_ovr_flag), 32'(v.req_tx_ovr));
        if (v.b[0][7]) chk($sformatf("vec%0d_tx_data", idx), 32'(tx_data), 32'(v.rdata));
        if (v.req_tx_ovr) begin
            pulse_status_clr();
            @(negedge sysclk);
            chk($sformatf("vec%0d_tx_ovr_cleared", idx), 32'(tx_ovr_flag), 0);
        end
        tx_reg_empty = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack0;
        int c0;

        //               nb    bytes (last..first)                  rdata  empty ovr
        vecs[0] = {3'd3, {8'h00, 8'h55, 8'hAA, 8'h05}, 8'h00, 1'b1, 1'b0};
        vecs[1] = {3'd3, {8'h00, 8'h22, 8'h11, 8'h7F}, 8'h00, 1'b1, 1'b0};
        vecs[2] = {3'd3, {8'h00, 8'hFF, 8'h00, 8'h83}, 8'h3C, 1'b1, 1'b0};
        vecs[3] = {3'd2, {8'h00, 8'h00, 8'h12, 8'h85}, 8'hC3, 1'b0, 1'b1};
        vecs[4] = {3'd4, {8'h03, 8'h02, 8'h01, 8'h00}, 8'h00, 1'b1, 1'b0};

        reset         = 1'b1;
        ss            = 1'b1;
        rx_data       = 8'h00;
        rx_data_ready = 1'b0;
        rx_error      = 1'b0;
        tx_reg_empty  = 1'b1;
        status_clr    = 1'b0;
        reg_rdata     = 8'hEE;

        repeat (2) @(negedge sysclk);
        chk_reset("por");
        @(posedge sysclk); #1;
        reset = 1'b0;
        repeat (4) @(posedge sysclk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Frame aborted right after a write command, then a fresh command.
        frame_begin();
        send_byte(8'h10);
        @(posedge sysclk); #1;
        ss = 1'b1;
        repeat (6) @(posedge sysclk);
        chk("abort_no_events", exp_q.size(), 0);
        exp_q.push_back({EV_WR, 8'h20, 8'h99});
        frame_begin();
        send_byte(8'h20);
        send_byte(8'h99);
        frame_end();
        wait_drain("abort_next_frame");

        // Byte arriving in the very cycle ss_s rises is acknowledged only.
        exp_q.push_back({EV_WR, 8'h40, 8'h01});
        ack0 = rx_ack_cnt;
        frame_begin();
        send_byte(8'h40);
        send_byte(8'h01);
        @(posedge sysclk); #1;
        ss = 1'b1;
        @(posedge sysclk);
        send_byte(8'h02);
        repeat (6) @(posedge sysclk);
        wait_drain("ss_rise_byte_events");
        chk("ss_rise_byte_acks", rx_ack_cnt - ack0, 3);

        // Receive overrun: single pulse, held pulse, then flag priority.
        c0 = clr_cnt;
        @(posedge sysclk); #1; rx_error = 1'b1;
        @(posedge sysclk); #1; rx_error = 1'b0;
        repeat (4) @(negedge sysclk);
        chk("clear_error_single", clr_cnt - c0, 1);
        chk("rx_ovr_set", 32'(rx_ovr_flag), 1);
        c0 = clr_cnt;
        @(posedge sysclk); #1; rx_error = 1'b1;
        repeat (2) @(posedge sysclk); #1; rx_error = 1'b0;
        repeat (4) @(negedge sysclk);
        chk("clear_error_held", clr_cnt - c0, 1);
        @(posedge sysclk); #1; rx_error = 1'b1; status_clr = 1'b1;
        @(posedge sysclk); #1; rx_error = 1'b0; status_clr = 1'b0;
        @(negedge sysclk);
        chk("rx_ovr_set_beats_clr", 32'(rx_ovr_flag), 1);
        pulse_status_clr();
        @(negedge sysclk);
        chk("rx_ovr_cleared", 32'(rx_ovr_flag), 0);

        // Reset in the middle of a write burst.
        @(posedge sysclk); #1; rx_error = 1'b1;
        @(posedge sysclk); #1; rx_error = 1'b0;
        exp_q.push_back({EV_WR, 8'h30, 8'h01});
        frame_begin();
        send_byte(8'h30);
        send_byte(8'h01);
        wait_drain("pre_reset_write");
        @(posedge sysclk); #1;
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        chk_reset("midframe");
        @(posedge sysclk); #1;
        reset = 1'b0;
        repeat (4) @(posedge sysclk);
        ack0 = rx_ack_cnt;
        send_byte(8'h02);
        frame_end();
        wait_drain("post_reset_no_write");
        chk("post_reset_ack", rx_ack_cnt - ack0, 1);

        exp_q.push_back({EV_WR, 8'h01, 8'h5A});
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h5A);
        frame_end();
        wait_drain("recovery_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_cmd_decoder.md
SPI_SLAVE_CMD_DECODER -- requirements
Module: spi_slave_cmd_decoder

Interface
REQ-001 Clock and reset: one clock `sysclk`; reset `reset` is asynchronous and active-high.
REQ-002 Parameter: `ADDR_W`, default 7, register address width; the command byte carries the address in bits [ADDR_W-1:0].
REQ-003 `sysclk` input 1: system clock, the same clock as the upstream SPI slave.
REQ-004 `reset` input 1: asynchronous active-high reset.
REQ-005 `ss` input 1: raw SPI slave select, active low.
REQ-006 `rx_data` input 8: received byte from the SPI slave receive register.
REQ-007 `rx_data_ready` input 1: received byte is waiting.
REQ-008 `rx_error` input 1: SPI slave receive-overrun flag.
REQ-009 `tx_reg_empty` input 1: SPI slave transmit register can be written.
REQ-010 `rx_reg_re` output 1: one-cycle read strobe for the receive register.
REQ-011 `tx_data` output 8: transmit byte to the SPI slave.
REQ-012 `tx_reg_we` output 1: one-cycle write strobe for the transmit register.
REQ-013 `clear_error` output 1: one-cycle pulse that clears the SPI slave receive error.
REQ-014 `reg_addr` output ADDR_W: register bus address.
REQ-015 `reg_wdata` output 8: register bus write data.
REQ-016 `reg_we` output 1: one-cycle register write strobe.
REQ-017 `reg_re` output 1: one-cycle register read strobe.
REQ-018 `reg_rdata` input 8: register read data, valid the cycle after `reg_re`.
REQ-019 `status_clr` input 1: synchronous clear of the sticky flags.
REQ-020 `rx_ovr_flag` output 1: sticky flag, SPI receive overrun was seen.
REQ-021 `tx_ovr_flag` output 1: sticky flag, transmit register was overwritten before it was sent.

Function
REQ-022 `ss` SHALL be synchronized through two flops (reset value 1) to give `ss_s`; all frame decisions SHALL use `ss_s`.
REQ-023 All outputs SHALL be registered.
REQ-024 FSM states SHALL be IDLE, CMD, WR_DATA, RD_FETCH and DRAIN.
REQ-025 Byte acceptance: a byte is accepted when `rx_data_ready`=1 and `rx_reg_re` is not asserted in the same cycle.
  - Each accepted byte SHALL produce exactly one `rx_reg_re` pulse in the following cycle.
  - This prevents double-consuming one byte.
REQ-026 IDLE:
  - `ss_s`=0 -> CMD.
  - Any accepted byte is discarded (still acknowledged with `rx_reg_re`).
REQ-027 CMD: on an accepted byte:
  - Latch `reg_addr`=`rx_data[ADDR_W-1:0]`.
  - `rx_data[7]`=0 (write) -> WR_DATA.
  - `rx_data[7]`=1 (read) -> pulse `reg_re` the next cycle with the latched address, then go to RD_FETCH.
REQ-028 WR_DATA: each accepted byte SHALL:
  - drive `reg_wdata`=`rx_data` with a one-cycle `reg_we` at the current `reg_addr`;
  - then increment `reg_addr` by 1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-029 RD_FETCH: the cycle after `reg_re`:
  - capture `reg_rdata` into `tx_data`;
  - pulse `tx_reg_we`;
  - if `tx_reg_empty`=0 in that cycle, set `tx_ovr_flag`;
  - go to DRAIN.
REQ-030 Read data SHALL be shifted out in the next SPI frame, because the SPI slave loads its shifter only while select is high.
REQ-031 DRAIN: accepted bytes SHALL be acknowledged and ignored until the frame ends.
REQ-032 `ss_s`=1 in any state other than RD_FETCH SHALL force IDLE the next cycle.
  - Writes already issued stand.
  - No further `reg_we`/`reg_re` SHALL be issued.
REQ-033 RD_FETCH SHALL always complete its capture before going to IDLE.
REQ-034 A byte accepted in the same cycle that `ss_s` rises SHALL be acknowledged but not acted on.
REQ-035 Receive overrun: `rx_error`=1 SHALL:
  - set `rx_ovr_flag`;
  - pulse `clear_error` for one cycle;
  - not pulse again while `rx_error` stays high through the cycle after the pulse.
REQ-036 Flag update priority: `status_clr` clears both sticky flags; a set event in the same cycle wins.
REQ-037 The `reg_we`, `reg_re` and `tx_reg_we` strobes SHALL never assert in the same cycle as each other.

Reset
REQ-038 While `reset`=1, the block SHALL hold:
  - FSM = IDLE and `ss_s` = 1;
  - `reg_addr` = 0, `reg_wdata` = 0x00, `tx_data` = 0x00;
  - all strobes, `clear_error`, `rx_ovr_flag` and `tx_ovr_flag` = 0.
REQ-039 Reset asserted mid-frame SHALL abort immediately.
  - After release, the block SHALL wait in IDLE for `ss_s` to be high and then low (a new frame) before decoding a command.

Verification
REQ-040 Write burst: frame {0x05, 0xAA, 0x55} -> `reg_we` at addr 0x05 with data 0xAA, then at 0x06 with 0x55; exactly 3 `rx_reg_re` pulses.
REQ-041 Wrap: frame {0x7F, 0x11, 0x22} -> writes at 0x7F, then at 0x00.
REQ-042 Read: frame {0x83}, `reg_rdata`=0x3C -> one `reg_re` at 0x03, then `tx_data`=0x3C with a `tx_reg_we` pulse; trailing bytes produce no strobes.
REQ-043 Read with `tx_reg_empty`=0 -> `tx_data` is overwritten and `tx_ovr_flag`=1; `status_clr` -> `tx_ovr_flag`=0.
REQ-044 Abort and error:
  - `ss` rises after the command byte 0x10 -> no `reg_we`; the next frame decodes a fresh command.
  - `rx_error` pulse -> one `clear_error` pulse and `rx_ovr_flag`=1.
REQ-045 Reset mid-WR_DATA -> all outputs return to their reset values; the next byte in the same frame produces no `reg_we`.
